// File: rtl/ddr2_apb_cfg_slave.sv
//------------------------------------------------------------------------------
// ddr2_apb_cfg_slave
//
// APB completer for the DDR2 memory controller configuration/status register
// file. It decodes word-aligned accesses, inserts WAIT_STATES access cycles
// before completing, and drives registered pready/prdata/pslverr. It also
// exports timing and control fields to the command scheduler and the init
// sequencer.
//
// Register map (paddr[7:0], paddr[1:0] ignored, paddr above bit 7 must be 0):
//   0x00 CTRL    RW  {30'b0, refresh_en, init_start}  init_start is write-1-pulse, reads 0
//   0x04 STATUS  RO  {30'b0, busy, init_done}
//   0x08 TIMING0 RW  {tRFC, tRAS, tRP, tRCD}
//   0x0C TIMING1 RW  {5'b0, tCL, tWR, tREFI}           bits [31:27] read as 0
//   0x10 ID      RO  VERSION
//   0x14 LOCK    RW  {31'b0, locked}                   only when DDR2_CFG_LOCK_EN is defined
//
// Optional feature macro: DDR2_CFG_LOCK_EN
//   Adds the LOCK register. Writing 32'hA5A5_0001 sets a sticky lock that
//   makes TIMING0/TIMING1 writes complete with pslverr=1 and no update.
//   Without the macro 0x14 is unmapped and no lock logic exists.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   psel, penable,
//   paddr, pwrite,
//   pwdata              APB request
//   pready, prdata,
//   pslverr             registered APB response
//   sts_init_done,
//   sts_busy            status inputs from the MC core
//   cfg_init_start      one-cycle pulse after a CTRL write with bit0=1
//   cfg_refresh_en      auto-refresh enable
//   cfg_timing0/1       timing register contents
//------------------------------------------------------------------------------
module ddr2_apb_cfg_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] TIMING0_RST = 32'h0F03_0303,
    parameter logic [31:0] TIMING1_RST = 32'h0304_0618,
    parameter logic [31:0] VERSION     = 32'h0002_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    input  logic                  sts_init_done,
    input  logic                  sts_busy,
    output logic                  cfg_init_start,
    output logic                  cfg_refresh_en,
    output logic [31:0]           cfg_timing0,
    output logic [31:0]           cfg_timing1
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // Word indices (paddr[7:2]) of the mapped registers.
    localparam logic [5:0]  IDX_CTRL        = 6'h00;
    localparam logic [5:0]  IDX_STATUS      = 6'h01;
    localparam logic [5:0]  IDX_TIMING0     = 6'h02;
    localparam logic [5:0]  IDX_TIMING1     = 6'h03;
    localparam logic [5:0]  IDX_ID          = 6'h04;
    localparam logic [31:0] TIMING1_WR_MASK = 32'h07FF_FFFF;

`ifdef DDR2_CFG_LOCK_EN
    localparam logic [5:0]  IDX_LOCK = 6'h05;
    localparam logic [31:0] LOCK_KEY = 32'hA5A5_0001;
    logic locked_q, locked_d;
`endif

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;     // word address, byte lanes dropped
    logic                  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic [31:0]           prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  init_start_q, init_start_d;
    logic                  refresh_en_q, refresh_en_d;
    logic [31:0]           timing0_q, timing0_d;
    logic [31:0]           timing1_q, timing1_d;

    logic                  complete;
    logic                  commit;
    logic [5:0]            word_idx;
    logic                  addr_hi_err;
    logic                  mapped;
    logic                  lock_err;
    logic                  acc_err;
    logic [31:0]           rd_val;

    // Byte-lane bits carry no meaning for word accesses.
    logic unused_paddr_lsb;
    assign unused_paddr_lsb = ^paddr[1:0];

    //--------------------------------------------------------------------------
    // Address decode of the latched request
    //--------------------------------------------------------------------------
    always_comb begin
        word_idx    = addr_q[5:0];
        addr_hi_err = ((addr_q >> 6) != '0);
        mapped      = 1'b1;
        rd_val      = '0;
        lock_err    = 1'b0;
        case (word_idx)
            IDX_CTRL:    rd_val = {30'b0, refresh_en_q, 1'b0};
            IDX_STATUS:  rd_val = {30'b0, sts_busy, sts_init_done};
            IDX_TIMING0: rd_val = timing0_q;
            IDX_TIMING1: rd_val = timing1_q;
            IDX_ID:      rd_val = VERSION;
`ifdef DDR2_CFG_LOCK_EN
            IDX_LOCK:    rd_val = {31'b0, locked_q};
`endif
            default:     mapped = 1'b0;
        endcase
`ifdef DDR2_CFG_LOCK_EN
        lock_err = locked_q && write_q &&
                   ((word_idx == IDX_TIMING0) || (word_idx == IDX_TIMING1));
`endif
        acc_err = addr_hi_err || !mapped || lock_err ||
                  (write_q && ((word_idx == IDX_STATUS) || (word_idx == IDX_ID)));
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state. Dropping psel mid-transfer aborts back to IDLE; a
    // psel&penable without a preceding setup cycle is ignored in IDLE.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (psel && !penable) state_d = ST_SETUP;
            ST_SETUP:  state_d = psel ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: if (pready_q || !psel) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs. The response is computed one cycle ahead so that pready,
    // prdata and pslverr leave flops; prdata therefore holds the register
    // value sampled on the edge that starts the pready cycle.
    //--------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        complete  = 1'b0;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    cnt_d   = 4'(WAIT_STATES);
                    addr_d  = paddr[ADDR_WIDTH-1:2];
                    write_d = pwrite;
                    wdata_d = pwdata;
                end
            end
            ST_SETUP: begin
                complete = psel && (cnt_q == 4'd0);
            end
            ST_ACCESS: begin
                if (!pready_q && psel) begin
                    if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        cnt_d    = 4'd0;
                        complete = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (complete) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = (write_q || acc_err) ? 32'h0 : rd_val;
        end
    end

    //--------------------------------------------------------------------------
    // Register file update: writes commit at the end of the pready cycle, so
    // cfg_* change one cycle after pready. Errored writes never commit.
    //--------------------------------------------------------------------------
    always_comb begin
        commit       = (state_q == ST_ACCESS) && pready_q && write_q && !pslverr_q;
        init_start_d = 1'b0;
        refresh_en_d = refresh_en_q;
        timing0_d    = timing0_q;
        timing1_d    = timing1_q;
`ifdef DDR2_CFG_LOCK_EN
        locked_d     = locked_q;
`endif
        if (commit) begin
            case (word_idx)
                IDX_CTRL: begin
                    init_start_d = wdata_q[0];
                    refresh_en_d = wdata_q[1];
                end
                IDX_TIMING0: timing0_d = wdata_q;
                IDX_TIMING1: timing1_d = wdata_q & TIMING1_WR_MASK;
`ifdef DDR2_CFG_LOCK_EN
                IDX_LOCK:    if (wdata_q == LOCK_KEY) locked_d = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Request latch, counter, response and register-file flops
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
            init_start_q <= 1'b0;
            refresh_en_q <= 1'b0;
            timing0_q    <= TIMING0_RST;
            timing1_q    <= TIMING1_RST;
`ifdef DDR2_CFG_LOCK_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            pready_q     <= pready_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
            init_start_q <= init_start_d;
            refresh_en_q <= refresh_en_d;
            timing0_q    <= timing0_d;
            timing1_q    <= timing1_d;
`ifdef DDR2_CFG_LOCK_EN
            locked_q     <= locked_d;
`endif
        end
    end

    assign pready         = pready_q;
    assign prdata         = prdata_q;
    assign pslverr        = pslverr_q;
    assign cfg_init_start = init_start_q;
    assign cfg_refresh_en = refresh_en_q;
    assign cfg_timing0    = timing0_q;
    assign cfg_timing1    = timing1_q;

endmodule
